// File: rtl/address_calc.sv
// rtl/address_calc.sv - coordinate (i, j, x_enc) to banked BRAM number/address mapper
// One registered stage; columns interleave across banks, high column bits fold into the word address.
module address_calc #(
  parameter int BRAM_NUMBER_SIZE  = 3,
  parameter int BRAM_ADDRESS_SIZE = 8,
  parameter int I_SIZE            = 1,
  parameter int J_SIZE            = 3,
  parameter int X_SIZE            = 3,
  parameter int DTYPE_BYTES_SIZE  = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [J_SIZE-1:0]            j,
  input  logic [I_SIZE-1:0]            i,
  input  logic [X_SIZE-1:0]            x_enc,
  output logic [BRAM_NUMBER_SIZE-1:0]  bram_number,
  output logic [BRAM_ADDRESS_SIZE-1:0] bram_address
);

  localparam int JH    = (J_SIZE > BRAM_NUMBER_SIZE) ? (J_SIZE - BRAM_NUMBER_SIZE) : 0;
  localparam int RAW_W = X_SIZE + I_SIZE + JH;

  logic [BRAM_NUMBER_SIZE-1:0]  number_next;
  logic [RAW_W-1:0]             raw_address;
  logic [BRAM_ADDRESS_SIZE-1:0] address_next;

  generate
    if (BRAM_NUMBER_SIZE < 1 || BRAM_ADDRESS_SIZE < 1 || I_SIZE < 1 ||
        J_SIZE < 1 || X_SIZE < 1 || DTYPE_BYTES_SIZE < 1) begin : g_bad_param
      $error("address_calc: every size parameter must be at least 1");
    end
  endgenerate

  // Bits of j above the bank select become the least significant address bits.
  generate
    if (JH > 0) begin : g_jhi
      assign number_next = j[BRAM_NUMBER_SIZE-1:0];
      assign raw_address = {x_enc, i, j[J_SIZE-1:BRAM_NUMBER_SIZE]};
    end else begin : g_no_jhi
      assign number_next = BRAM_NUMBER_SIZE'(j);
      assign raw_address = {x_enc, i};
    end
  endgenerate

  // Size cast zero-extends a narrow raw address or keeps the low bits of a wide one.
  assign address_next = BRAM_ADDRESS_SIZE'(raw_address);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bram_number  <= '0;
      bram_address <= '0;
    end else begin
      bram_number  <= number_next;
      bram_address <= address_next;
    end
  end

endmodule

// File: tb/tb_address_calc.sv
// tb/tb_address_calc.sv - scoreboard bench for address_calc (default, wide-j and truncating instances)
module tb_address_calc;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] j = '0;
  logic [4:0] jw = '0;
  logic [0:0] i = '0;
  logic [2:0] x_enc = '0;

  logic [2:0] bn0, bn1, bn2;
  logic [7:0] ba0, ba1;
  logic [1:0] ba2;

  int total = 0;
  int bad = 0;

  typedef struct {
    int n0; int a0; int n1; int a1; int n2; int a2;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  address_calc dut (
    .clock(clock), .reset_n(reset_n), .j(j), .i(i), .x_enc(x_enc),
    .bram_number(bn0), .bram_address(ba0)
  );

  address_calc #(.J_SIZE(5)) dut_hi (
    .clock(clock), .reset_n(reset_n), .j(jw), .i(i), .x_enc(x_enc),
    .bram_number(bn1), .bram_address(ba1)
  );

  address_calc #(.BRAM_ADDRESS_SIZE(2)) dut_tr (
    .clock(clock), .reset_n(reset_n), .j(j), .i(i), .x_enc(x_enc),
    .bram_number(bn2), .bram_address(ba2)
  );

  function automatic int calc_num(int jv, int bns);
    return jv % (1 << bns);
  endfunction

  function automatic int calc_addr(int jv, int iv, int xv, int jsz, int bns, int bas);
    int jh_w;
    int raw;
    jh_w = (jsz > bns) ? (jsz - bns) : 0;
    raw  = xv * (1 << (1 + jh_w)) + iv * (1 << jh_w) + (jv / (1 << bns));
    return raw % (1 << bas);
  endfunction

  // Monitor: compares every instance against the expectation queued one cycle earlier.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (bn0 !== 3'(e.n0)) begin bad++; $display("FAIL sb_num0 got=%0d want=%0d", bn0, e.n0); end
      total++; if (ba0 !== 8'(e.a0)) begin bad++; $display("FAIL sb_addr0 got=%0d want=%0d", ba0, e.a0); end
      total++; if (bn1 !== 3'(e.n1)) begin bad++; $display("FAIL sb_num_hi got=%0d want=%0d", bn1, e.n1); end
      total++; if (ba1 !== 8'(e.a1)) begin bad++; $display("FAIL sb_addr_hi got=%0d want=%0d", ba1, e.a1); end
      total++; if (bn2 !== 3'(e.n2)) begin bad++; $display("FAIL sb_num_tr got=%0d want=%0d", bn2, e.n2); end
      total++; if (ba2 !== 2'(e.a2)) begin bad++; $display("FAIL sb_addr_tr got=%0d want=%0d", ba2, e.a2); end
    end
  end

  task automatic drive(input int jv, input int jwv, input int iv, input int xv, input bit rst_n);
    exp_t e;
    j = 3'(jv); jw = 5'(jwv); i = 1'(iv); x_enc = 3'(xv); reset_n = rst_n;
    if (!rst_n) begin
      e = '{0, 0, 0, 0, 0, 0};
    end else begin
      e.n0 = calc_num(jv, 3);  e.a0 = calc_addr(jv, iv, xv, 3, 3, 8);
      e.n1 = calc_num(jwv, 3); e.a1 = calc_addr(jwv, iv, xv, 5, 3, 8);
      e.n2 = calc_num(jv, 3);  e.a2 = calc_addr(jv, iv, xv, 3, 3, 2);
    end
    sb.push_back(e);
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    drive(5, 5, 1, 3, 1'b0);
    drive(5, 5, 1, 3, 1'b0);
    total++; if (bn0 !== 3'd0) begin bad++; $display("FAIL reset_num got=%0d want=0", bn0); end
    total++; if (ba0 !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", ba0); end
    drive(5, 5, 1, 3, 1'b1);
    total++; if (bn0 !== 3'd5) begin bad++; $display("FAIL release_num got=%0d want=5", bn0); end
    total++; if (ba0 !== 8'd7) begin bad++; $display("FAIL release_addr got=%0d want=7", ba0); end
  endtask

  task automatic test_column_sweep();
    for (int k = 0; k < 8; k++) begin
      drive(k, k, 1, 3, 1'b1);
      total++; if (bn0 !== 3'(k)) begin bad++; $display("FAIL sweep_num got=%0d want=%0d", bn0, k); end
      total++; if (ba0 !== 8'd7) begin bad++; $display("FAIL sweep_addr got=%0d want=7", ba0); end
    end
    drive(0, 0, 1, 3, 1'b1);
    total++; if (bn0 !== 3'd0) begin bad++; $display("FAIL sweep_wrap got=%0d want=0", bn0); end
  endtask

  task automatic test_corners();
    drive(7, 7, 0, 0, 1'b1);
    total++; if (bn0 !== 3'd7 || ba0 !== 8'd0) begin bad++; $display("FAIL corner_low got=%0d/%0d want=7/0", bn0, ba0); end
    drive(0, 0, 1, 7, 1'b1);
    total++; if (bn0 !== 3'd0 || ba0 !== 8'd15) begin bad++; $display("FAIL corner_high got=%0d/%0d want=0/15", bn0, ba0); end
  endtask

  task automatic test_high_bits();
    drive(5, 13, 1, 3, 1'b1);
    total++; if (bn1 !== 3'd5 || ba1 !== 8'd29) begin bad++; $display("FAIL high_bits got=%0d/%0d want=5/29", bn1, ba1); end
    drive(7, 31, 1, 7, 1'b1);
    total++; if (bn1 !== 3'd7 || ba1 !== 8'd63) begin bad++; $display("FAIL high_bits_max got=%0d/%0d want=7/63", bn1, ba1); end
  endtask

  task automatic test_truncation();
    drive(6, 6, 1, 3, 1'b1);
    total++; if (ba2 !== 2'd3 || bn2 !== 3'd6) begin bad++; $display("FAIL trunc got=%0d/%0d want=6/3", bn2, ba2); end
    drive(1, 1, 0, 5, 1'b1);
    total++; if (ba2 !== 2'd2) begin bad++; $display("FAIL trunc_wrap got=%0d want=2", ba2); end
  endtask

  task automatic test_mid_reset();
    drive(2, 18, 1, 4, 1'b1);
    drive(3, 27, 0, 6, 1'b1);
    drive(4, 9, 1, 1, 1'b0);
    total++; if (bn0 !== 3'd0 || ba0 !== 8'd0 || ba1 !== 8'd0) begin bad++; $display("FAIL mid_reset got=%0d/%0d/%0d want=0/0/0", bn0, ba0, ba1); end
    drive(4, 9, 1, 1, 1'b1);
    total++; if (bn0 !== 3'd4 || ba0 !== 8'd3) begin bad++; $display("FAIL mid_resume got=%0d/%0d want=4/3", bn0, ba0); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'b1);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_column_sweep();
    test_corners();
    test_high_bits();
    test_truncation();
    test_mid_reset();
    test_back_to_back();
    @(posedge clock);
    #3;
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/address_calc.md
Name:
address_calc

Overview:
- Maps a matrix element coordinate to a physical BRAM location in Mithril's banked on-chip memory.
- Inputs are a row index (i), a column index (j) and an encoded operand/region selector (x_enc).
- Outputs are a bank select (bram_number) and a word address within that bank (bram_address).
- Columns are interleaved across banks, so consecutive j values hit different BRAMs. The block sits between the sequencing logic and the BRAM array read/write ports.

Parameters:
- BRAM_NUMBER_SIZE, 3: width of the bank select; 2^BRAM_NUMBER_SIZE banks.
- BRAM_ADDRESS_SIZE, 8: width of the per-bank word address.
- I_SIZE, 1: width of the row index i.
- J_SIZE, 3: width of the column index j.
- X_SIZE, 3: width of the operand/region selector x_enc.
- DTYPE_BYTES_SIZE, 1: bytes per element. It is carried for interface compatibility only. One element occupies one BRAM word, so this parameter has no effect on the address arithmetic.

Ports:
- clock, input, 1: rising-edge clock.
- reset_n, input, 1: synchronous active-low reset.
- j, input, J_SIZE: column index.
- i, input, I_SIZE: row index.
- x_enc, input, X_SIZE: operand/region selector.
- bram_number, output, BRAM_NUMBER_SIZE: registered bank select.
- bram_address, output, BRAM_ADDRESS_SIZE: registered word address within the bank.

Behaviour:
- Interface: one clock, `clock`. Reset `reset_n` is synchronous and active-low.
- Reset:
  - When reset_n is 0 at a rising edge, bram_number and bram_address are both 0 after that edge.
  - Reset has priority over the input capture in the same cycle.
  - Reset mid-stream discards the in-flight result; the next non-reset edge produces a normal result.
- Latency:
  - Exactly 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N.
  - Outputs are stable for the whole following cycle.
  - There is no handshake: a new result is produced every cycle (throughput 1/cycle).
- Bank select:
  - Form j_ext by zero-extending j to max(J_SIZE, BRAM_NUMBER_SIZE) bits.
  - bram_number = j_ext[BRAM_NUMBER_SIZE-1:0], i.e. j mod 2^BRAM_NUMBER_SIZE.
- High column bits:
  - If J_SIZE > BRAM_NUMBER_SIZE: j_hi = j >> BRAM_NUMBER_SIZE, with width JH = J_SIZE - BRAM_NUMBER_SIZE.
  - Otherwise j_hi is empty (JH = 0). The implementation handles the JH = 0 case with a generate branch, not a zero-width vector.
- Word address:
  - Raw address = concatenation {x_enc, i, j_hi}, MSB first.
  - Numerically: raw = (x_enc << (I_SIZE+JH)) | (i << JH) | j_hi.
- Width rules:
  - Raw width is X_SIZE + I_SIZE + JH.
  - If the raw width is ≤ BRAM_ADDRESS_SIZE, zero-extend it.
  - If it is larger, keep the low BRAM_ADDRESS_SIZE bits (wrap-around, no saturation, no error flag).
- Arithmetic: purely combinational bit-slicing ahead of the output register. No adders, no carries.
- Boundaries:
  - j at its maximum wraps the bank in sequence 7→0 across consecutive j values (defaults).
  - Any X/Z on the inputs is not required to be handled.
- Parameter validation: all parameters must be ≥ 1. An elaboration-time check ($error or equivalent) fires if any parameter is 0.

Test Plan:
- Reset: hold reset_n = 0 with j=5, i=1, x_enc=3 for 2 edges → bram_number=0, bram_address=0. Release reset_n → after the next edge bram_number=5, bram_address=7.
- Column sweep (defaults): i=1, x_enc=3, apply j=0..7 one per cycle → one cycle later bram_number = 0,1,...,7 in order and bram_address = 7 throughout. Then apply j=0 → bram_number=0 (wrap).
- Region/row corners (defaults): x_enc=0, i=0, j=7 → number 7, address 0. x_enc=7, i=1, j=0 → number 0, address 15.
- High column bits (J_SIZE=5, BRAM_NUMBER_SIZE=3): j=13, i=1, x_enc=3 → bram_number=5, bram_address=29.
- Truncation (BRAM_ADDRESS_SIZE=2): x_enc=3, i=1 → raw 7, bram_address=3. Bank select is unaffected.
- Mid-stream reset: drive a changing j sequence, then assert reset_n=0 for one edge → outputs 0 for that cycle only. The following edges resume producing the correct mapping with 1-cycle latency.
